// File: rtl/input_conditioner.sv
// Input conditioner: synchronizes a noisy asynchronous input, debounces it with a
// consecutive-sample FSM and emits a single-cycle pulse on the selected debounced edge.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_SEL        = 0,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw_in,
  input  logic             enable,
  output logic             a,
  output logic             level,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam int               DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             RISE_EN  = (EDGE_SEL != 1);
  localparam logic             FALL_EN  = (EDGE_SEL != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE_LOW     = 2'd0,
    CONFIRM_HIGH = 2'd1,
    IDLE_HIGH    = 2'd2,
    CONFIRM_LOW  = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Stage 1: synchronizer chain; only sync_bit is seen by the rest of the block
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Stage 2: debounce FSM, counts consecutive samples differing from the stable level
  state_t            state_q, state_d;
  logic [DB_W-1:0]   cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              busy_q, busy_d;
  logic              rise_d, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (sync_bit) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE_HIGH;
            level_d = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = CONFIRM_HIGH;
            cnt_d   = DB_W'(1);
          end
        end
      end
      CONFIRM_HIGH: begin
        if (!sync_bit) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync_bit) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE_LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = CONFIRM_LOW;
            cnt_d   = DB_W'(1);
          end
        end
      end
      CONFIRM_LOW: begin
        if (sync_bit) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign busy_d = (state_d == CONFIRM_HIGH) || (state_d == CONFIRM_LOW);

  // Stage 3: edge select, enable mask and saturating pulse counter
  logic             a_q, a_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;

  assign a_d         = enable && ((rise_d && RISE_EN) || (fall_d && FALL_EN));
  assign pulse_cnt_d = a_d ? sat_inc(pulse_cnt_q) : pulse_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE_LOW;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      busy_q      <= 1'b0;
      a_q         <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      busy_q      <= busy_d;
      a_q         <= a_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign a         = a_q;
  assign level     = level_q;
  assign busy      = busy_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: four parameter variants share one stimulus stream and are
// checked every cycle against a sample-history model, plus hand-computed directed checks.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_in;
  logic       enable;
  logic [3:0] dut_a, dut_level, dut_busy;
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  int n_cmp = 0;
  int n_err = 0;

  // Variant parameters: 0 default, 1 falling-edge, 2 both edges, 3 both edges / deep sync / short debounce / 2-bit count
  int P_S  [4] = '{2, 2, 2, 3};
  int P_D  [4] = '{4, 4, 4, 2};
  int P_E  [4] = '{0, 1, 2, 2};
  int P_CW [4] = '{8, 8, 8, 2};

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_SEL(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .raw_in(raw_in), .enable(enable),
    .a(dut_a[0]), .level(dut_level[0]), .busy(dut_busy[0]), .pulse_cnt(cnt0));
  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_SEL(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .raw_in(raw_in), .enable(enable),
    .a(dut_a[1]), .level(dut_level[1]), .busy(dut_busy[1]), .pulse_cnt(cnt1));
  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_SEL(2), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .raw_in(raw_in), .enable(enable),
    .a(dut_a[2]), .level(dut_level[2]), .busy(dut_busy[2]), .pulse_cnt(cnt2));
  input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2), .EDGE_SEL(2), .CNT_W(2)) u3 (
    .clk(clk), .rst(rst), .raw_in(raw_in), .enable(enable),
    .a(dut_a[3]), .level(dut_level[3]), .busy(dut_busy[3]), .pulse_cnt(cnt3));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int i);
    case (i)
      0: return 32'(cnt0);
      1: return 32'(cnt1);
      2: return 32'(cnt2);
      3: return 32'(cnt3);
      default: return 32'd0;
    endcase
  endfunction

  // Model: raw samples logged since reset; the level flips when the last D synchronized
  // samples all disagree with it. The synchronized sample at edge k is raw from edge k-S.
  bit rawlog [8192];
  int mk;
  bit m_level [4];
  bit m_a     [4];
  bit m_busy  [4];
  bit prev_a  [4];
  int m_cnt   [4];

  function automatic bit sv(input int i, input int kk);
    int idx;
    idx = kk - P_S[i];
    return (idx >= 0) ? rawlog[idx] : 1'b0;
  endfunction

  task automatic m_reset();
    mk = 0;
    for (int i = 0; i < 4; i++) begin
      m_level[i] = 1'b0;
      m_a[i]     = 1'b0;
      m_busy[i]  = 1'b0;
      m_cnt[i]   = 0;
      prev_a[i]  = 1'b0;
    end
  endtask

  task automatic m_step();
    bit flip, match;
    for (int i = 0; i < 4; i++) begin
      flip = 1'b1;
      for (int j = 0; j < P_D[i]; j++)
        if (sv(i, mk - j) == m_level[i]) flip = 1'b0;
      if (flip) begin
        m_level[i] = !m_level[i];
        match = m_level[i] ? (P_E[i] != 1) : (P_E[i] >= 1);
        m_a[i] = match && enable;
        if (m_a[i] && m_cnt[i] < (1 << P_CW[i]) - 1) m_cnt[i]++;
      end else begin
        m_a[i] = 1'b0;
      end
      m_busy[i] = !flip && (sv(i, mk) != m_level[i]);
    end
    if (mk < 8192) rawlog[mk] = raw_in;
    mk++;
  endtask

  task automatic check_model();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("inst%0d.a", i),         32'(dut_a[i]),     32'(m_a[i]));
      chk($sformatf("inst%0d.level", i),     32'(dut_level[i]), 32'(m_level[i]));
      chk($sformatf("inst%0d.busy", i),      32'(dut_busy[i]),  32'(m_busy[i]));
      chk($sformatf("inst%0d.pulse_cnt", i), dut_cnt(i),        32'(m_cnt[i]));
      chk($sformatf("inst%0d.adjacent_a", i), 32'(prev_a[i] && dut_a[i]), 32'd0);
      prev_a[i] = dut_a[i];
    end
  endtask

  always @(posedge clk) begin
    if (rst) m_reset();
    else     m_step();
    #1;
    check_model();
  end

  always @(posedge rst) begin
    m_reset();
    #1;
    check_model();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    raw_in = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst    = 1'b0;
    raw_in = 1'b0;
    enable = 1'b1;
    #1 rst = 1'b1;
    #2;
    for (int i = 0; i < 4; i++) begin
      chk("reset.level", 32'(dut_level[i]), 32'd0);
      chk("reset.pulse_cnt", dut_cnt(i), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Clean rise held for 10 sampling edges, then fall
    do_reset();
    @(negedge clk);
    raw_in = 1'b1;
    for (int e = 0; e <= 24; e++) begin
      tick();
      if (e == 1) chk("rise.busy_e1", 32'(dut_busy[0]), 32'd0);
      if (e >= 2 && e <= 4) begin
        chk("rise.busy_confirm", 32'(dut_busy[0]), 32'd1);
        chk("rise.level_pending", 32'(dut_level[0]), 32'd0);
      end
      if (e == 4) chk("rise.inst3_a", 32'(dut_a[3]), 32'd1);
      if (e == 5) begin
        chk("rise.level_e5", 32'(dut_level[0]), 32'd1);
        chk("rise.a_e5", 32'(dut_a[0]), 32'd1);
        chk("rise.cnt_e5", 32'(cnt0), 32'd1);
        chk("rise.busy_e5", 32'(dut_busy[0]), 32'd0);
        chk("rise.fallsel_a", 32'(dut_a[1]), 32'd0);
        chk("rise.bothsel_a", 32'(dut_a[2]), 32'd1);
      end
      if (e == 6) chk("rise.a_e6", 32'(dut_a[0]), 32'd0);
      if (e >= 12 && e <= 14) chk("fall.busy_confirm", 32'(dut_busy[0]), 32'd1);
      if (e == 14) chk("fall.inst3_a", 32'(dut_a[3]), 32'd1);
      if (e == 15) begin
        chk("fall.level_e15", 32'(dut_level[0]), 32'd0);
        chk("fall.risesel_a", 32'(dut_a[0]), 32'd0);
        chk("fall.fallsel_a", 32'(dut_a[1]), 32'd1);
        chk("fall.bothsel_a", 32'(dut_a[2]), 32'd1);
        chk("fall.cnt_risesel", 32'(cnt0), 32'd1);
        chk("fall.cnt_fallsel", 32'(cnt1), 32'd1);
        chk("fall.cnt_bothsel", 32'(cnt2), 32'd2);
        chk("fall.cnt_inst3", 32'(cnt3), 32'd2);
      end
      if (e == 9) begin
        @(negedge clk);
        raw_in = 1'b0;
      end
    end

    // Glitch of three sampling edges
    do_reset();
    @(negedge clk);
    raw_in = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      tick();
      chk("glitch.level", 32'(dut_level[0]), 32'd0);
      chk("glitch.a", 32'(dut_a[0]), 32'd0);
      if (e >= 2 && e <= 4) chk("glitch.busy_up", 32'(dut_busy[0]), 32'd1);
      if (e == 5) chk("glitch.busy_down", 32'(dut_busy[0]), 32'd0);
      if (e == 2) begin
        @(negedge clk);
        raw_in = 1'b0;
      end
    end
    chk("glitch.cnt", 32'(cnt0), 32'd0);

    // Enable masking through a full rise, then an enabled fall
    do_reset();
    @(negedge clk);
    enable = 1'b0;
    raw_in = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      tick();
      if (e == 5) begin
        chk("mask.level", 32'(dut_level[0]), 32'd1);
        chk("mask.a", 32'(dut_a[0]), 32'd0);
        chk("mask.bothsel_a", 32'(dut_a[2]), 32'd0);
      end
    end
    chk("mask.cnt", 32'(cnt0), 32'd0);
    chk("mask.cnt_bothsel", 32'(cnt2), 32'd0);
    @(negedge clk);
    enable = 1'b1;
    raw_in = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 5) begin
        chk("unmask.bothsel_a", 32'(dut_a[2]), 32'd1);
        chk("unmask.bothsel_cnt", 32'(cnt2), 32'd1);
        chk("unmask.level", 32'(dut_level[2]), 32'd0);
        chk("unmask.risesel_a", 32'(dut_a[0]), 32'd0);
      end
    end

    // Asynchronous reset while confirming a rise
    do_reset();
    @(negedge clk);
    raw_in = 1'b1;
    for (int e = 0; e <= 3; e++) tick();
    chk("areset.busy_before", 32'(dut_busy[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("areset.busy", 32'(dut_busy[i]), 32'd0);
      chk("areset.level", 32'(dut_level[i]), 32'd0);
      chk("areset.a", 32'(dut_a[i]), 32'd0);
      chk("areset.cnt", dut_cnt(i), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 4) chk("areset.a_e4", 32'(dut_a[0]), 32'd0);
      if (e == 5) begin
        chk("areset.a_e5", 32'(dut_a[0]), 32'd1);
        chk("areset.level_e5", 32'(dut_level[0]), 32'd1);
      end
      if (e == 6) chk("areset.a_e6", 32'(dut_a[0]), 32'd0);
    end

    // raw_in toggling every cycle
    do_reset();
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      raw_in = !raw_in;
      tick();
      for (int i = 0; i < 4; i++) begin
        chk("toggle.level", 32'(dut_level[i]), 32'd0);
        chk("toggle.a", 32'(dut_a[i]), 32'd0);
      end
    end

    // Saturation of the 2-bit counter across five qualifying edges
    do_reset();
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      raw_in = !raw_in;
      for (int e = 0; e < 8; e++) tick();
      chk("sat.cnt2bit", 32'(cnt3), 32'(sat_exp[p]));
      chk("sat.cnt8bit", 32'(cnt2), 32'(p + 1));
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
